axis_packet_source: RTL and testbench
=====================================

Name: axis_packet_source

Overview:
- AXI4-Stream transmitter (master only) that generates one packet of programmable length per start request.
- 8-bit default data path; payload is a deterministic pattern; TLAST marks the final beat.
- Serves as the traffic source feeding the team's AXIS slave-side blocks (register slices, sinks) in the streaming pipeline and test harnesses.
- Fully honours downstream backpressure.

Parameters:
- DATA_W, 8, width of m_axis_tdata and seed.
- LEN_W, 8, width of pkt_len; maximum packet is 2^LEN_W-1 beats.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- start  in  1  request one packet; sampled only in IDLE.
- pkt_len  in  LEN_W  beats in packet; 0 means the request is ignored.
- seed  in  DATA_W  payload of first beat.
- mode  in  1  0 = incrementing payload (+1 per beat), 1 = constant payload (seed every beat).
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tdata  out  DATA_W  output payload.
- m_axis_tlast  out  1  final beat of packet.
- busy  out  1  high from the cycle after start acceptance until the last handshake completes.
- done  out  1  one-cycle pulse after the last beat handshake.
- pkt_count  out  CNT_W  number of completed packets; wraps modulo 2^CNT_W.

Behaviour:
- Reset (aresetn=0 at a clock edge): all outputs are 0.
  - FSM goes to IDLE.
  - Internal length, beat counter and payload registers are cleared.
- All outputs are registered. No combinational path from m_axis_tready to any output.
- FSM states: IDLE, SEND.
- IDLE behaviour:
  - start=1 and pkt_len!=0 at edge N: latch pkt_len, seed and mode; go to SEND.
  - At N+1: m_axis_tvalid=1, m_axis_tdata=seed, m_axis_tlast=(pkt_len==1), busy=1. Latency from start to first valid is one cycle.
  - start=1 with pkt_len==0: no action; stay IDLE; done not pulsed.
- SEND behaviour:
  - A handshake is m_axis_tvalid && m_axis_tready at an edge.
  - Handshake on a non-last beat: beat counter increments. The next beat is presented on the following cycle with no bubble.
    - Next tdata = previous tdata + 1 (mod 2^DATA_W, so 8'hFF wraps to 8'h00) if mode=0; unchanged if mode=1.
    - tlast asserts on beat index pkt_len-1 (0-based).
  - Handshake on the last beat: at the next cycle m_axis_tvalid=0, m_axis_tlast=0, busy=0, done=1 for exactly one cycle, pkt_count+1. FSM returns to IDLE.
- AXIS rules:
  - Once m_axis_tvalid=1, it stays 1 until the handshake.
  - m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0, for any stall length.
- start while in SEND: ignored. It is not queued, and changes to pkt_len, seed or mode are ignored.
- Back-to-back packets: start is accepted in the done cycle (the FSM is already IDLE). Minimum spacing is one idle cycle between the last beat of one packet and the first beat of the next.
- tready held high throughout a packet: a packet of L beats takes exactly L cycles of tvalid.
- Reset mid-packet: tvalid drops at the reset edge. The packet is truncated with no tlast, no done pulse, and pkt_count=0.
- pkt_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package axis_pkg holds:
  - State enum {IDLE, SEND}.
  - Default width constants (DATA_W=8, LEN_W=8, CNT_W=16).
  - Mode encodings MODE_INC=0 and MODE_CONST=1.
- One natural sub-module, axis_pattern_gen: the payload register, loaded with the seed and advanced by +1 or held according to mode on an advance strobe.
- The FSM, beat counter and handshake logic stay in the top level.

Test Plan:
- Length 4, seed 8'h10, mode 0, tready always 1 -> tdata 10,11,12,13 on consecutive cycles; tlast only with 13; done one cycle after; pkt_count=1.
- Length 3, seed 8'hFE, mode 0 -> tdata FE,FF,00; tlast with 00.
- Length 5, mode 1, seed 8'hA5, tready toggling 1-0-0-1 pattern -> five beats of A5; tdata and tlast stable during every stall; exactly 5 handshakes; tlast on the fifth.
- pkt_len=0 with start -> no tvalid, busy stays 0, done stays 0, pkt_count unchanged. Then start pulsed during SEND of a length-6 packet -> ignored; only 6 beats are sent.
- Start asserted in the done cycle -> second packet's first beat appears 1 cycle later; pkt_count reaches 2.
- aresetn=0 after beat 2 of a length-8 packet -> tvalid=0 at the next edge, no tlast, no done, pkt_count=0. A new start after reset produces a full, correct packet.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and defaults for the AXI4-Stream packet source.
package axis_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic MODE_INC   = 1'b0;
  localparam logic MODE_CONST = 1'b1;

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

endpackage

// File: rtl/axis_pattern_gen.sv
// Payload register: loads the seed, then increments or holds on each advance.
module axis_pattern_gen
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  input  logic              advance,
  input  logic              mode,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = seed;
    end else if (advance && (mode != MODE_CONST)) begin
      data_d = data_q + DATA_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/axis_packet_source.sv
// AXI4-Stream master emitting one pattern packet of programmable length per start.
module axis_packet_source
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] seed,
  input  logic              mode,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_count
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               mode_q, mode_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load, advance;
  logic [LEN_W-1:0]   beat_next;

  assign beat_next = beat_q + LEN_W'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    beat_d   = beat_q;
    mode_d   = mode_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    load     = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && (pkt_len != '0)) begin
          len_d    = pkt_len;
          mode_d   = mode;
          beat_d   = '0;
          load     = 1'b1;
          tvalid_d = 1'b1;
          tlast_d  = (pkt_len == LEN_W'(1));
          busy_d   = 1'b1;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (tvalid_q && m_axis_tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            state_d  = StIdle;
          end else begin
            beat_d  = beat_next;
            advance = 1'b1;
            // len_q is at least 1 in SEND, so len_q - 1 cannot underflow.
            tlast_d = (beat_next == (len_q - LEN_W'(1)));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      len_q    <= '0;
      beat_q   <= '0;
      mode_q   <= MODE_INC;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      mode_q   <= mode_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  axis_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (load),
    .seed    (seed),
    .advance (advance),
    .mode    (mode_q),
    .data    (m_axis_tdata)
  );

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_axis_packet_source.sv
// Directed bench for axis_packet_source: per-cycle vector table plus stall and reset sequences.
module tb_axis_packet_source;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [7:0]  pkt_len;
  logic [7:0]  seed;
  logic        mode;
  logic        m_axis_tready;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  axis_packet_source u_dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .pkt_len       (pkt_len),
    .seed          (seed),
    .mode          (mode),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pkt_count)
  );

  // Inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic        rstn;
    logic        st;
    logic [7:0]  len;
    logic [7:0]  sd;
    logic        md;
    logic        rdy;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        b;
    logic        dn;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t t);
    @(negedge aclk);
    aresetn       = t.rstn;
    start         = t.st;
    pkt_len       = t.len;
    seed          = t.sd;
    mode          = t.md;
    m_axis_tready = t.rdy;
    @(posedge aclk);
    #1;
    chk({tag, ".tvalid"}, 32'(m_axis_tvalid), 32'(t.v));
    if (t.v) chk({tag, ".tdata"}, 32'(m_axis_tdata), 32'(t.d));
    chk({tag, ".tlast"}, 32'(m_axis_tlast), 32'(t.l));
    chk({tag, ".busy"}, 32'(busy), 32'(t.b));
    chk({tag, ".done"}, 32'(done), 32'(t.dn));
    chk({tag, ".pkt_count"}, 32'(pkt_count), 32'(t.c));
  endtask

  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    aresetn = 1'b0; start = 1'b0; pkt_len = '0; seed = '0; mode = 1'b0; m_axis_tready = 1'b0;

    //             rstn st len    seed   md rdy  v  d      l  b  dn c
    tbl.push_back('{0, 0, 8'd0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 16'd0});
    tbl.push_back('{0, 1, 8'd4, 8'h10, 0, 1,   0, 8'h00, 0, 0, 0, 16'd0});
    // length 4, incrementing from 10
    tbl.push_back('{1, 1, 8'd4, 8'h10, 0, 1,   1, 8'h10, 0, 1, 0, 16'd0});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   1, 8'h11, 0, 1, 0, 16'd0});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   1, 8'h12, 0, 1, 0, 16'd0});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   1, 8'h13, 1, 1, 0, 16'd0});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 16'd1});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 16'd1});
    // length 3 wrapping FE, FF, 00
    tbl.push_back('{1, 1, 8'd3, 8'hFE, 0, 1,   1, 8'hFE, 0, 1, 0, 16'd1});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   1, 8'hFF, 0, 1, 0, 16'd1});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   1, 8'h00, 1, 1, 0, 16'd1});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 16'd2});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 16'd2});
    // zero length is ignored
    tbl.push_back('{1, 1, 8'd0, 8'h55, 0, 1,   0, 8'h00, 0, 0, 0, 16'd2});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 16'd2});
    // length 6 constant 20; start pulses during SEND must be ignored
    tbl.push_back('{1, 1, 8'd6, 8'h20, 1, 1,   1, 8'h20, 0, 1, 0, 16'd2});
    tbl.push_back('{1, 1, 8'd2, 8'h99, 0, 1,   1, 8'h20, 0, 1, 0, 16'd2});
    tbl.push_back('{1, 1, 8'd2, 8'h99, 0, 1,   1, 8'h20, 0, 1, 0, 16'd2});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   1, 8'h20, 0, 1, 0, 16'd2});
    tbl.push_back('{1, 1, 8'd9, 8'h77, 0, 1,   1, 8'h20, 0, 1, 0, 16'd2});
    tbl.push_back('{1, 1, 8'd9, 8'h77, 0, 1,   1, 8'h20, 1, 1, 0, 16'd2});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 16'd3});
    // start taken in the done cycle: next packet one cycle later
    tbl.push_back('{1, 1, 8'd2, 8'h40, 0, 1,   1, 8'h40, 0, 1, 0, 16'd3});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   1, 8'h41, 1, 1, 0, 16'd3});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 16'd4});
    tbl.push_back('{1, 0, 8'd0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 16'd4});

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Length 5 constant A5 under a 1-0-0-1 tready pattern.
    begin
      logic       pv, pl, seen_done;
      logic [7:0] pd;
      int         hs;
      hs = 0;
      seen_done = 1'b0;
      step("stall_start", '{1, 1, 8'd5, 8'hA5, 1, 0, 1, 8'hA5, 0, 1, 0, 16'd4});
      start = 1'b0;
      for (int c = 0; c < 60 && !seen_done; c++) begin
        @(negedge aclk);
        m_axis_tready = pat[c % 4];
        pv = m_axis_tvalid;
        pd = m_axis_tdata;
        pl = m_axis_tlast;
        @(posedge aclk);
        #1;
        if (pv && !m_axis_tready) begin
          chk($sformatf("stall%0d.tvalid", c), 32'(m_axis_tvalid), 32'd1);
          chk($sformatf("stall%0d.tdata", c), 32'(m_axis_tdata), 32'(pd));
          chk($sformatf("stall%0d.tlast", c), 32'(m_axis_tlast), 32'(pl));
        end
        if (pv && m_axis_tready) begin
          hs++;
          chk($sformatf("stall_hs%0d.tdata", hs), 32'(pd), 32'hA5);
          chk($sformatf("stall_hs%0d.tlast", hs), 32'(pl), 32'(hs == 5));
        end
        if (done) seen_done = 1'b1;
      end
      chk("stall.done_seen", 32'(seen_done), 32'd1);
      chk("stall.handshakes", 32'(hs), 32'd5);
      chk("stall.pkt_count", 32'(pkt_count), 32'd5);
      step("stall_idle", '{1, 0, 8'd0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 16'd5});
    end

    // Reset after beat 2 of a length-8 packet, then a clean packet.
    step("rst_b0", '{1, 1, 8'd8, 8'h30, 0, 1, 1, 8'h30, 0, 1, 0, 16'd5});
    step("rst_b1", '{1, 0, 8'd0, 8'h00, 0, 1, 1, 8'h31, 0, 1, 0, 16'd5});
    step("rst_b2", '{1, 0, 8'd0, 8'h00, 0, 1, 1, 8'h32, 0, 1, 0, 16'd5});
    step("rst_hit", '{0, 0, 8'd0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 16'd0});
    step("rst_idle", '{1, 0, 8'd0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 16'd0});
    step("rst_idle2", '{1, 0, 8'd0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 16'd0});
    step("post_b0", '{1, 1, 8'd3, 8'h07, 0, 1, 1, 8'h07, 0, 1, 0, 16'd0});
    step("post_b1", '{1, 0, 8'd0, 8'h00, 0, 1, 1, 8'h08, 0, 1, 0, 16'd0});
    step("post_b2", '{1, 0, 8'd0, 8'h00, 0, 1, 1, 8'h09, 1, 1, 0, 16'd0});
    step("post_done", '{1, 0, 8'd0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1, 16'd1});
    step("post_idle", '{1, 0, 8'd0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 16'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
